// File: rtl/camera_pkg.sv
// Shared types and helpers for the camera frame writer.
// Optional build macro: CAMERA_DOWNSAMPLE_2X_EN (keep every other pixel and line).
package camera_pkg;

  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 240;

  typedef enum logic {
    SYNC    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  // Number of pixels actually written per frame for a given input resolution.
  function automatic int unsigned frame_size(input int unsigned h, input int unsigned v);
`ifdef CAMERA_DOWNSAMPLE_2X_EN
    return (h / 2) * (v / 2);
`else
    return h * v;
`endif
  endfunction

  localparam int unsigned FRAME_PIXELS = frame_size(H_ACTIVE_DEF, V_ACTIVE_DEF);

  // Keep the top bits of each channel: {R[15:12], G[10:7], B[4:1]}.
  function automatic logic [11:0] rgb565_to_rgb444(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Raster position, pixel index and frame size checking for the frame writer.
// Honours CAMERA_DOWNSAMPLE_2X_EN for the accept decision and expected frame size.
module frame_addr_gen
  import camera_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int PIX_AW   = 17
) (
  input  logic              p_clock_in,
  input  logic              rst_in,
  input  logic              clear,
  input  logic              count_en,
  output logic              accept,
  output logic [PIX_AW-1:0] pix_idx,
  output logic              count_ok
);

  localparam int unsigned     FRAME   = frame_size(H_ACTIVE, V_ACTIVE);
  localparam logic [PIX_AW:0] FRAME_N = (PIX_AW + 1)'(FRAME);
  localparam int              XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int              YW      = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]   X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]   Y_MAX   = YW'(V_ACTIVE);

  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  // One extra bit so a frame exactly 2^PIX_AW pixels long can still be counted.
  logic [PIX_AW:0] cnt;
  logic [PIX_AW:0] cnt_nxt;
  logic            overflow;
  logic            sample_ok;
  logic            drop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sample_ok = 1'b1;
`ifdef CAMERA_DOWNSAMPLE_2X_EN
    sample_ok = ~x[0] & ~y[0];
`endif
    accept   = count_en & sample_ok & (cnt != FRAME_N);
    drop     = count_en & sample_ok & (cnt == FRAME_N);
    cnt_nxt  = cnt + (PIX_AW + 1)'(accept);
    // Includes a pixel arriving in the same cycle as the end-of-frame pulse.
    count_ok = (cnt_nxt == FRAME_N) & ~overflow & ~drop;
    pix_idx  = cnt[PIX_AW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge p_clock_in or posedge rst_in) begin
    if (rst_in) begin
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (count_en) begin
      cnt <= cnt_nxt;
      if (drop) overflow <= 1'b1;
      if (x == X_LAST) begin
        x <= '0;
        if (y != Y_MAX) y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/camera_frame_writer.sv
// Converts camera RGB565 pixels to RGB444 and writes them into a ping-pong frame BRAM.
// Build with CAMERA_DOWNSAMPLE_2X_EN to store a half-resolution image instead.
module camera_frame_writer
  import camera_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int PIX_AW   = 17
) (
  input  logic              p_clock_in,
  input  logic              rst_in,
  input  logic [15:0]       pixel_data_in,
  input  logic              pixel_valid_in,
  input  logic              frame_done_in,
  input  logic              capture_en_in,
  output logic              wr_en_out,
  output logic [PIX_AW:0]   wr_addr_out,
  output logic [11:0]       wr_data_out,
  output logic              read_bank_out,
  output logic              frame_ready_out,
  output logic              frame_error_out
);

  state_t            state;
  state_t            state_nxt;
  logic              wr_bank;
  logic              count_en;
  logic              accept;
  logic              count_ok;
  logic              commit;
  logic              discard;
  logic [PIX_AW-1:0] pix_idx;

  assign count_en = (state == CAPTURE) & pixel_valid_in;

  // Counters restart on every frame boundary; outside CAPTURE they are idle anyway.
  frame_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .PIX_AW   (PIX_AW)
  ) u_addr_gen (
    .p_clock_in (p_clock_in),
    .rst_in     (rst_in),
    .clear      (frame_done_in),
    .count_en   (count_en),
    .accept     (accept),
    .pix_idx    (pix_idx),
    .count_ok   (count_ok)
  );

  always_ff @(posedge p_clock_in or posedge rst_in) begin
    if (rst_in) state <= SYNC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    discard   = 1'b0;
    unique case (state)
      SYNC: begin
        if (frame_done_in && capture_en_in) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (frame_done_in) begin
          commit  = count_ok;
          discard = ~count_ok;
          if (!capture_en_in) state_nxt = SYNC;
        end
      end
    endcase
  end

  // wr_bank always differs from read_bank_out, so the display bank is never written.
  always_ff @(posedge p_clock_in or posedge rst_in) begin
    if (rst_in) begin
      wr_en_out       <= 1'b0;
      wr_addr_out     <= '0;
      wr_data_out     <= '0;
      frame_ready_out <= 1'b0;
      frame_error_out <= 1'b0;
      read_bank_out   <= 1'b1;
      wr_bank         <= 1'b0;
    end else begin
      wr_en_out       <= accept;
      frame_ready_out <= commit;
      frame_error_out <= discard;
      if (accept) begin
        wr_addr_out <= {wr_bank, pix_idx};
        wr_data_out <= rgb565_to_rgb444(pixel_data_in);
      end
      if (commit) begin
        read_bank_out <= wr_bank;
        wr_bank       <= ~wr_bank;
      end
    end
  end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Scoreboard bench for camera_frame_writer on a 4x2 frame with randomized traffic.
module tb_camera_frame_writer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 3;
`ifdef CAMERA_DOWNSAMPLE_2X_EN
  localparam int FRAME = (H / 2) * (V / 2);
`else
  localparam int FRAME = H * V;
`endif

  logic          p_clock_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [15:0]   pixel_data_in = '0;
  logic          pixel_valid_in = 1'b0;
  logic          frame_done_in = 1'b0;
  logic          capture_en_in = 1'b0;
  logic          wr_en_out;
  logic [AW:0]   wr_addr_out;
  logic [11:0]   wr_data_out;
  logic          read_bank_out;
  logic          frame_ready_out;
  logic          frame_error_out;

  camera_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_AW(AW)) dut (
    .p_clock_in      (p_clock_in),
    .rst_in          (rst_in),
    .pixel_data_in   (pixel_data_in),
    .pixel_valid_in  (pixel_valid_in),
    .frame_done_in   (frame_done_in),
    .capture_en_in   (capture_en_in),
    .wr_en_out       (wr_en_out),
    .wr_addr_out     (wr_addr_out),
    .wr_data_out     (wr_data_out),
    .read_bank_out   (read_bank_out),
    .frame_ready_out (frame_ready_out),
    .frame_error_out (frame_error_out)
  );

  always #5 p_clock_in = ~p_clock_in;

  int cyc = 0;
  always @(posedge p_clock_in) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [AW:0] addr;
    logic [11:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    bit ready;
    bit rbank;
    int cyc;
  } ev_t;

  wr_t wr_q[$];
  ev_t ev_q[$];

  // Reference model state: frame-level view of the writer.
  bit m_cap   = 1'b0;
  bit m_wbank = 1'b0;
  bit m_rbank = 1'b1;
  int m_raw   = 0;
  int m_acc   = 0;
  bit m_ovf   = 1'b0;
  bit en_lvl  = 1'b1;

  logic [15:0] pat [3] = '{16'hF800, 16'h07E0, 16'h001F};

  function automatic logic [11:0] expect_rgb444(input logic [15:0] d);
    int r5, g6, b5;
    r5 = int'(d) / 2048;
    g6 = (int'(d) / 32) % 64;
    b5 = int'(d) % 32;
    return 12'((r5 / 2) * 256 + (g6 / 4) * 16 + b5 / 2);
  endfunction

  task automatic model_step(input logic [15:0] d, input bit v, input bit done, input bit en, input int c);
    int  x, y;
    bit  keep, ok;
    wr_t w;
    ev_t e;
    if (m_cap && v) begin
      x = m_raw % H;
      y = m_raw / H;
      if (y > V) y = V;
`ifdef CAMERA_DOWNSAMPLE_2X_EN
      keep = (x % 2 == 0) && (y % 2 == 0);
`else
      keep = 1'b1;
`endif
      if (keep) begin
        if (m_acc < FRAME) begin
          w.addr = (AW + 1)'(int'(m_wbank) * (1 << AW) + m_acc);
          w.data = expect_rgb444(d);
          w.cyc  = c + 1;
          wr_q.push_back(w);
          m_acc++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_raw++;
    end
    if (done) begin
      if (m_cap) begin
        ok = (m_acc == FRAME) && !m_ovf;
        if (ok) begin
          m_rbank = m_wbank;
          m_wbank = !m_wbank;
        end
        e.ready = ok;
        e.rbank = m_rbank;
        e.cyc   = c + 1;
        ev_q.push_back(e);
        m_cap = en;
      end else if (en) begin
        m_cap = 1'b1;
      end
      m_raw = 0;
      m_acc = 0;
      m_ovf = 1'b0;
    end
  endtask

  task automatic drive(input logic [15:0] d, input bit v, input bit done);
    @(posedge p_clock_in);
    #1;
    pixel_data_in  = d;
    pixel_valid_in = v;
    frame_done_in  = done;
    capture_en_in  = en_lvl;
    model_step(d, v, done, en_lvl, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'h0, 1'b0, 1'b0);
  endtask

  // Sends n pixels; the end-of-frame pulse rides on the last pixel when merge is set.
  task automatic send_frame(input int n, input bit merge, input int gap_max, input bit use_pat);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = (use_pat && i < 3) ? pat[i] : 16'($urandom);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      drive(d, 1'b1, merge && (i == n - 1));
    end
    if (!merge || n == 0) drive(16'h0, 1'b0, 1'b1);
    idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en_out), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr_out), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data_out), 32'd0);
    check({tag, "_read_bank"}, 32'(read_bank_out), 32'd1);
    check({tag, "_ready"}, 32'(frame_ready_out), 32'd0);
    check({tag, "_error"}, 32'(frame_error_out), 32'd0);
  endtask

  // Monitor: compares every DUT write and frame pulse against the scoreboard queues.
  wr_t mw;
  ev_t me;
  always @(negedge p_clock_in) begin
    if (!rst_in) begin
      if (wr_en_out) begin
        if (wr_q.size() == 0) begin
          check("spurious_wr_en", 32'(wr_en_out), 32'd0);
        end else begin
          mw = wr_q.pop_front();
          check("wr_addr", 32'(wr_addr_out), 32'(mw.addr));
          check("wr_data", 32'(wr_data_out), 32'(mw.data));
          check("wr_latency_cycle", 32'(cyc), 32'(mw.cyc));
        end
      end
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
        mw = wr_q.pop_front();
        check("missing_write_cycle", 32'(cyc), 32'(mw.cyc));
      end
      if (frame_ready_out || frame_error_out) begin
        if (ev_q.size() == 0) begin
          check("spurious_frame_ready", 32'(frame_ready_out), 32'd0);
          check("spurious_frame_error", 32'(frame_error_out), 32'd0);
        end else begin
          me = ev_q.pop_front();
          check("frame_ready", 32'(frame_ready_out), 32'(me.ready));
          check("frame_error", 32'(frame_error_out), 32'(!me.ready));
          check("read_bank_after_frame", 32'(read_bank_out), 32'(me.rbank));
          check("frame_pulse_cycle", 32'(cyc), 32'(me.cyc));
        end
      end
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        me = ev_q.pop_front();
        check("missing_frame_pulse_cycle", 32'(cyc), 32'(me.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge p_clock_in);
    #1;
    check_reset_outputs("reset");
    rst_in = 1'b0;

    // Pixels before any frame boundary must be ignored.
    send_frame(8, 1'b0, 0, 1'b0);
    check("sync_read_bank", 32'(read_bank_out), 32'(m_rbank));

    // First good frame commits bank 0, second fills bank 1.
    send_frame(8, 1'b0, 0, 1'b1);
    check("first_commit_read_bank", 32'(read_bank_out), 32'(m_rbank));
    send_frame(8, 1'b0, 1, 1'b1);

    // Short frame, long frame, then a frame whose last pixel meets frame_done.
    send_frame(6, 1'b0, 0, 1'b0);
    check("short_read_bank", 32'(read_bank_out), 32'(m_rbank));
    send_frame(10, 1'b0, 0, 1'b0);
    check("long_read_bank", 32'(read_bank_out), 32'(m_rbank));
    send_frame(8, 1'b1, 0, 1'b0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 3; i++) drive(16'($urandom), 1'b1, 1'b0);
    idle(2);
    check("queues_drained_before_reset", 32'(wr_q.size() + ev_q.size()), 32'd0);
    @(posedge p_clock_in);
    #1;
    rst_in = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    wr_q.delete();
    ev_q.delete();
    m_cap   = 1'b0;
    m_wbank = 1'b0;
    m_rbank = 1'b1;
    m_raw   = 0;
    m_acc   = 0;
    m_ovf   = 1'b0;
    #2;
    rst_in = 1'b0;

    // Tail of the interrupted frame is ignored until a fresh boundary.
    send_frame(5, 1'b0, 0, 1'b0);
    send_frame(8, 1'b0, 0, 1'b1);

    // Randomized frames: sizes around the boundary, gaps and capture enable changes.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) en_lvl = !en_lvl;
      n = (f % 3 == 0) ? H * V : $urandom_range(0, H * V + 3);
      send_frame(n, 1'($urandom_range(0, 1)), 2, 1'b0);
    end
    en_lvl = 1'b1;
    send_frame(8, 1'b0, 0, 1'b0);

    idle(4);
    check("final_wr_queue_empty", 32'(wr_q.size()), 32'd0);
    check("final_ev_queue_empty", 32'(ev_q.size()), 32'd0);
    check("final_read_bank", 32'(read_bank_out), 32'(m_rbank));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
